// File: rtl/alu_mc_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mc_if
//  Purpose  : Execute-stage ALU request/response bundle. The requester drives
//             the operation, operands and start strobe; the ALU returns the
//             busy/done handshake with the registered result and NZCV flags.
//  Ports    : none (signal bundle only)
//             start, ALUControl[3:0], a, b, carry_in   requester -> ALU
//             busy, done, Result, ALUFlags[3:0]        ALU -> requester
//  Revision : 1.0  initial release
// ============================================================================
interface alu_mc_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [3:0]       ALUControl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Result;
    logic [3:0]       ALUFlags;

    modport master (
        output start, ALUControl, a, b, carry_in,
        input  busy, done, Result, ALUFlags
    );

    modport slave (
        input  start, ALUControl, a, b, carry_in,
        output busy, done, Result, ALUFlags
    );
endinterface
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mc
//  Purpose  : Multi-cycle ALU. ADD/SUB/ADC/SBC, AND/ORR/EOR/MOV and
//             LSL/LSR/ASR/ROR complete in one cycle; MUL/UMULH run an
//             iterative shift-add multiplier for WIDTH cycles. Result and
//             {N,Z,C,V} are registered and qualified by a one-cycle done.
//  Ports    : clk    rising-edge clock
//             reset  asynchronous, active-low reset
//             bus    alu_mc_if.slave (start/ALUControl/a/b/carry_in in,
//                    busy/done/Result/ALUFlags out)
//  Revision : 1.0  initial release
// ============================================================================
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = 8
) (
    input  wire logic clk,
    input  wire logic reset,
    alu_mc_if.slave   bus
);

    localparam logic [3:0] c_OP_ADD   = 4'b0000;
    localparam logic [3:0] c_OP_SUB   = 4'b0001;
    localparam logic [3:0] c_OP_AND   = 4'b0010;
    localparam logic [3:0] c_OP_ORR   = 4'b0011;
    localparam logic [3:0] c_OP_EOR   = 4'b0100;
    localparam logic [3:0] c_OP_MOV   = 4'b0101;
    localparam logic [3:0] c_OP_ADC   = 4'b0110;
    localparam logic [3:0] c_OP_SBC   = 4'b0111;
    localparam logic [3:0] c_OP_LSL   = 4'b1000;
    localparam logic [3:0] c_OP_LSR   = 4'b1001;
    localparam logic [3:0] c_OP_ASR   = 4'b1010;
    localparam logic [3:0] c_OP_ROR   = 4'b1011;
    localparam logic [3:0] c_OP_MUL   = 4'b1100;
    localparam logic [3:0] c_OP_UMULH = 4'b1101;

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MULT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic             w_sub;
    logic             w_cin;
    logic [WIDTH-1:0] w_bop;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;
    logic [31:0]      w_samt;
    logic [31:0]      w_rot;
    logic             w_is_shift;
    logic             w_is_mul;
    logic [WIDTH:0]   w_lsl;
    logic [WIDTH:0]   w_lsr;
    logic [WIDTH:0]   w_asr;
    logic [WIDTH-1:0] w_ror;
    logic [WIDTH-1:0] w_op_res;
    logic             w_op_c;
    logic             w_op_v;
    logic [3:0]       w_op_flags;

    assign w_sub = (bus.ALUControl == c_OP_SUB) || (bus.ALUControl == c_OP_SBC);
    // SUB always adds the +1 of two's complement; ADC/SBC take it from the C flag.
    assign w_cin = (bus.ALUControl == c_OP_SUB) ||
                   (((bus.ALUControl == c_OP_ADC) || (bus.ALUControl == c_OP_SBC)) && bus.carry_in);
    assign w_bop = w_sub ? ~bus.b : bus.b;
    assign w_sum = {1'b0, bus.a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_cin};
    assign w_ovf = ~(bus.a[WIDTH-1] ^ bus.b[WIDTH-1] ^ w_sub) & (bus.a[WIDTH-1] ^ w_sum[WIDTH-1]);

    assign w_samt     = 32'(bus.b[SHW-1:0]);
    assign w_rot      = w_samt % 32'(WIDTH);
    assign w_is_shift = (bus.ALUControl[3:2] == 2'b10);
    assign w_is_mul   = (bus.ALUControl == c_OP_MUL) || (bus.ALUControl == c_OP_UMULH);

    // Each shift runs on a WIDTH+1 vector whose extra bit catches the last
    // bit shifted out; amounts beyond WIDTH naturally yield 0 (LSL/LSR) or
    // a full sign fill (ASR), so no separate over-range path is needed.
    assign w_lsl = {1'b0, bus.a} << w_samt;
    assign w_lsr = {bus.a, 1'b0} >> w_samt;
    assign w_asr = $signed({bus.a, 1'b0}) >>> w_samt;
    // When w_rot is 0 the left term shifts by WIDTH and vanishes.
    assign w_ror = (bus.a >> w_rot) | (bus.a << (32'(WIDTH) - w_rot));

    always_comb begin
        w_op_res = '0;
        w_op_c   = 1'b0;
        w_op_v   = 1'b0;
        case (bus.ALUControl)
            c_OP_ADD, c_OP_SUB, c_OP_ADC, c_OP_SBC: begin
                w_op_res = w_sum[WIDTH-1:0];
                w_op_c   = w_sum[WIDTH];
                w_op_v   = w_ovf;
            end
            c_OP_AND: w_op_res = bus.a & bus.b;
            c_OP_ORR: w_op_res = bus.a | bus.b;
            c_OP_EOR: w_op_res = bus.a ^ bus.b;
            c_OP_MOV: w_op_res = bus.b;
            c_OP_LSL: begin
                w_op_res = w_lsl[WIDTH-1:0];
                w_op_c   = w_lsl[WIDTH];
            end
            c_OP_LSR: begin
                w_op_res = w_lsr[WIDTH:1];
                w_op_c   = w_lsr[0];
            end
            c_OP_ASR: begin
                w_op_res = w_asr[WIDTH:1];
                w_op_c   = w_asr[0];
            end
            c_OP_ROR: begin
                w_op_res = w_ror;
                w_op_c   = w_ror[WIDTH-1];
            end
            default: begin
                // Reserved (and MUL/UMULH, which never take this path):
                // zero result, flags settle to 0100 through Z.
                w_op_res = '0;
            end
        endcase
        // A zero shift amount passes a through and preserves the C flag.
        if (w_is_shift && (w_samt == 32'd0)) begin
            w_op_res = bus.a;
            w_op_c   = bus.carry_in;
        end
    end

    assign w_op_flags = {w_op_res[WIDTH-1], (w_op_res == '0), w_op_c, w_op_v};

    // ------------------------------------------------------------------
    // Control FSM and iterative multiplier
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   w_mcand_nxt;
    logic [2*WIDTH-1:0] r_mplier;
    logic [2*WIDTH-1:0] w_mplier_nxt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_hi;
    logic               w_hi_nxt;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   w_result_nxt;
    logic [3:0]         r_flags;
    logic [3:0]         w_flags_nxt;
    logic               r_done;
    logic               w_done_nxt;

    logic [2*WIDTH-1:0] w_acc_sum;
    logic [WIDTH-1:0]   w_prod_sel;

    assign w_acc_sum  = r_acc + (r_mcand[0] ? r_mplier : {(2*WIDTH){1'b0}});
    // The final iteration's sum is used directly so completion lands in the
    // same cycle as the last add rather than one cycle later.
    assign w_prod_sel = r_hi ? w_acc_sum[2*WIDTH-1:WIDTH] : w_acc_sum[WIDTH-1:0];

    always_comb begin
        w_state_nxt  = r_state;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_hi_nxt     = r_hi;
        w_result_nxt = r_result;
        w_flags_nxt  = r_flags;
        w_done_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (w_is_mul) begin
                        w_mcand_nxt  = bus.b;
                        w_mplier_nxt = {{WIDTH{1'b0}}, bus.a};
                        w_acc_nxt    = '0;
                        w_cnt_nxt    = '0;
                        w_hi_nxt     = bus.ALUControl[0];
                        w_state_nxt  = ST_MULT;
                    end else begin
                        w_result_nxt = w_op_res;
                        w_flags_nxt  = w_op_flags;
                        w_done_nxt   = 1'b1;
                    end
                end
            end
            ST_MULT: begin
                w_acc_nxt    = w_acc_sum;
                w_mplier_nxt = r_mplier << 1;
                w_mcand_nxt  = r_mcand >> 1;
                w_cnt_nxt    = r_cnt + 1'b1;
                if (r_cnt == c_LAST) begin
                    w_result_nxt = w_prod_sel;
                    w_flags_nxt  = {w_prod_sel[WIDTH-1], (w_prod_sel == '0), 2'b00};
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_hi     <= 1'b0;
            r_result <= '0;
            r_flags  <= 4'b0000;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_hi     <= w_hi_nxt;
            r_result <= w_result_nxt;
            r_flags  <= w_flags_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign bus.busy     = (r_state == ST_MULT);
    assign bus.done     = r_done;
    assign bus.Result   = r_result;
    assign bus.ALUFlags = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_mc
//  Purpose  : Directed self-checking bench for alu_mc (WIDTH=32, SHW=8).
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_mc;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    alu_mc_if #(.WIDTH(32)) bus_if ();

    alu_mc #(.WIDTH(32), .SHW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pulses start for one cycle; returns at the negedge of the next cycle,
    // where a single-cycle op's done/Result are visible.
    task automatic do_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic cin);
        @(negedge clk);
        bus_if.start      = 1'b1;
        bus_if.ALUControl = op;
        bus_if.a          = av;
        bus_if.b          = bv;
        bus_if.carry_in   = cin;
        @(negedge clk);
        bus_if.start = 1'b0;
    endtask

    // Launches a multiply and waits (bounded) for busy to drop. Operands are
    // scrambled after the start cycle; inject_at>=0 pulses an ADD start at
    // that busy cycle. Returns at the negedge of the completion cycle.
    task automatic run_mul(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                           input int inject_at, output int nbusy, output int early_done);
        nbusy      = 0;
        early_done = 0;
        @(negedge clk);
        bus_if.start      = 1'b1;
        bus_if.ALUControl = op;
        bus_if.a          = av;
        bus_if.b          = bv;
        bus_if.carry_in   = 1'b0;
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.a     = 32'hDEAD_BEEF;
        bus_if.b     = 32'h1234_5678;
        while ((bus_if.busy === 1'b1) && (nbusy < 100)) begin
            nbusy++;
            if (bus_if.done === 1'b1) early_done++;
            if (nbusy == inject_at) begin
                bus_if.start      = 1'b1;
                bus_if.ALUControl = 4'b0000;
                bus_if.a          = 32'd1;
                bus_if.b          = 32'd1;
            end else begin
                bus_if.start = 1'b0;
            end
            @(negedge clk);
        end
        bus_if.start = 1'b0;
    endtask

    task automatic test_reset;
        reset             = 1'b0;
        bus_if.start      = 1'b0;
        bus_if.ALUControl = 4'b0000;
        bus_if.a          = '0;
        bus_if.b          = '0;
        bus_if.carry_in   = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus_if.busy); end
        checks++; if (bus_if.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus_if.done); end
        checks++; if (bus_if.Result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", bus_if.Result); end
        checks++; if (bus_if.ALUFlags !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", bus_if.ALUFlags); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_arith;
        do_op(4'b0000, 32'hFFFF_FFFF, 32'h1, 1'b0);
        checks++; if (bus_if.done !== 1'b1) begin errors++; $display("FAIL add_done got=%b exp=1", bus_if.done); end
        checks++; if (bus_if.Result !== 32'h0) begin errors++; $display("FAIL add_result got=%h exp=00000000", bus_if.Result); end
        checks++; if (bus_if.ALUFlags !== 4'b0110) begin errors++; $display("FAIL add_flags got=%b exp=0110", bus_if.ALUFlags); end
        @(negedge clk);
        checks++; if (bus_if.done !== 1'b0) begin errors++; $display("FAIL add_done_pulse got=%b exp=0", bus_if.done); end

        do_op(4'b0001, 32'h8000_0000, 32'h1, 1'b0);
        checks++; if (bus_if.Result !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sub_result got=%h exp=7fffffff", bus_if.Result); end
        checks++; if (bus_if.ALUFlags !== 4'b0011) begin errors++; $display("FAIL sub_flags got=%b exp=0011", bus_if.ALUFlags); end

        do_op(4'b0110, 32'h1, 32'h1, 1'b1);
        checks++; if (bus_if.Result !== 32'h3) begin errors++; $display("FAIL adc_result got=%h exp=00000003", bus_if.Result); end
        checks++; if (bus_if.ALUFlags !== 4'b0000) begin errors++; $display("FAIL adc_flags got=%b exp=0000", bus_if.ALUFlags); end

        // 5 + ~3 + 0 = 0x1_00000001
        do_op(4'b0111, 32'h5, 32'h3, 1'b0);
        checks++; if (bus_if.Result !== 32'h1) begin errors++; $display("FAIL sbc_result got=%h exp=00000001", bus_if.Result); end
        checks++; if (bus_if.ALUFlags !== 4'b0010) begin errors++; $display("FAIL sbc_flags got=%b exp=0010", bus_if.ALUFlags); end

        do_op(4'b0010, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1);
        checks++; if (bus_if.Result !== 32'h0) begin errors++; $display("FAIL and_result got=%h exp=00000000", bus_if.Result); end
        checks++; if (bus_if.ALUFlags !== 4'b0100) begin errors++; $display("FAIL and_flags got=%b exp=0100", bus_if.ALUFlags); end
    endtask

    task automatic test_shift;
        do_op(4'b1000, 32'h8000_0001, 32'd1, 1'b0);
        checks++; if (bus_if.Result !== 32'h2) begin errors++; $display("FAIL lsl_result got=%h exp=00000002", bus_if.Result); end
        checks++; if (bus_if.ALUFlags !== 4'b0010) begin errors++; $display("FAIL lsl_flags got=%b exp=0010", bus_if.ALUFlags); end

        do_op(4'b1010, 32'h8000_0000, 32'd40, 1'b0);
        checks++; if (bus_if.Result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL asr40_result got=%h exp=ffffffff", bus_if.Result); end
        checks++; if (bus_if.ALUFlags !== 4'b1010) begin errors++; $display("FAIL asr40_flags got=%b exp=1010", bus_if.ALUFlags); end

        do_op(4'b1011, 32'h1, 32'd33, 1'b0);
        checks++; if (bus_if.Result !== 32'h8000_0000) begin errors++; $display("FAIL ror33_result got=%h exp=80000000", bus_if.Result); end
        checks++; if (bus_if.ALUFlags !== 4'b1010) begin errors++; $display("FAIL ror33_flags got=%b exp=1010", bus_if.ALUFlags); end

        // Zero amount: pass-through, C from carry_in; upper b bits ignored.
        do_op(4'b1001, 32'h1234_5678, 32'hFFFF_FF00, 1'b1);
        checks++; if (bus_if.Result !== 32'h1234_5678) begin errors++; $display("FAIL lsr0_result got=%h exp=12345678", bus_if.Result); end
        checks++; if (bus_if.ALUFlags !== 4'b0010) begin errors++; $display("FAIL lsr0_flags got=%b exp=0010", bus_if.ALUFlags); end

        do_op(4'b1001, 32'h8000_0000, 32'd40, 1'b1);
        checks++; if (bus_if.Result !== 32'h0) begin errors++; $display("FAIL lsr40_result got=%h exp=00000000", bus_if.Result); end
        checks++; if (bus_if.ALUFlags !== 4'b0100) begin errors++; $display("FAIL lsr40_flags got=%b exp=0100", bus_if.ALUFlags); end

        // LSR by exactly WIDTH: result 0, C = a[31]
        do_op(4'b1001, 32'h8000_0000, 32'd32, 1'b0);
        checks++; if (bus_if.ALUFlags !== 4'b0110) begin errors++; $display("FAIL lsr32_flags got=%b exp=0110", bus_if.ALUFlags); end

        do_op(4'b1010, 32'h8000_0010, 32'd4, 1'b0);
        checks++; if (bus_if.Result !== 32'hF800_0001) begin errors++; $display("FAIL asr4_result got=%h exp=f8000001", bus_if.Result); end
    endtask

    task automatic test_mul;
        int nb;
        int ed;
        run_mul(4'b1100, 32'hFFFF_FFFF, 32'h2, -1, nb, ed);
        checks++; if (nb !== 32) begin errors++; $display("FAIL mul_busy_cycles got=%0d exp=32", nb); end
        checks++; if (ed !== 0) begin errors++; $display("FAIL mul_early_done got=%0d exp=0", ed); end
        checks++; if ((bus_if.done !== 1'b1) || (bus_if.busy !== 1'b0)) begin errors++; $display("FAIL mul_done got=%b/%b exp=1/0", bus_if.done, bus_if.busy); end
        checks++; if (bus_if.Result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mul_result got=%h exp=fffffffe", bus_if.Result); end
        checks++; if (bus_if.ALUFlags !== 4'b1000) begin errors++; $display("FAIL mul_flags got=%b exp=1000", bus_if.ALUFlags); end
        @(negedge clk);
        checks++; if (bus_if.done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse got=%b exp=0", bus_if.done); end

        run_mul(4'b1101, 32'hFFFF_FFFF, 32'h2, -1, nb, ed);
        checks++; if ((nb !== 32) || (bus_if.done !== 1'b1)) begin errors++; $display("FAIL umulh_timing got=%0d/%b exp=32/1", nb, bus_if.done); end
        checks++; if (bus_if.Result !== 32'h1) begin errors++; $display("FAIL umulh_result got=%h exp=00000001", bus_if.Result); end
        checks++; if (bus_if.ALUFlags !== 4'b0000) begin errors++; $display("FAIL umulh_flags got=%b exp=0000", bus_if.ALUFlags); end

        // 0x10000 * 0x10000 = 0x1_00000000
        run_mul(4'b1100, 32'h0001_0000, 32'h0001_0000, -1, nb, ed);
        checks++; if (bus_if.Result !== 32'h0) begin errors++; $display("FAIL mul_lo_zero_result got=%h exp=00000000", bus_if.Result); end
        checks++; if (bus_if.ALUFlags !== 4'b0100) begin errors++; $display("FAIL mul_lo_zero_flags got=%b exp=0100", bus_if.ALUFlags); end

        run_mul(4'b1100, 32'd12345, 32'd6789, -1, nb, ed);
        checks++; if (bus_if.Result !== 32'd83810205) begin errors++; $display("FAIL mul_small_result got=%0d exp=83810205", bus_if.Result); end
    endtask

    task automatic test_start_ignored;
        int nb;
        int ed;
        run_mul(4'b1100, 32'hFFFF_FFFF, 32'h2, 10, nb, ed);
        checks++; if (nb !== 32) begin errors++; $display("FAIL ign_busy_cycles got=%0d exp=32", nb); end
        checks++; if (ed !== 0) begin errors++; $display("FAIL ign_early_done got=%0d exp=0", ed); end
        checks++; if (bus_if.Result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL ign_result got=%h exp=fffffffe", bus_if.Result); end
        @(negedge clk);
        checks++; if (bus_if.done !== 1'b0) begin errors++; $display("FAIL ign_no_queue got=%b exp=0", bus_if.done); end
    endtask

    task automatic test_reset_mid;
        int stray;
        stray = 0;
        @(negedge clk);
        bus_if.start      = 1'b1;
        bus_if.ALUControl = 4'b1100;
        bus_if.a          = 32'hFFFF_FFFF;
        bus_if.b          = 32'h3;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus_if.busy); end
        checks++; if (bus_if.Result !== 32'h0) begin errors++; $display("FAIL midrst_result got=%h exp=00000000", bus_if.Result); end
        checks++; if (bus_if.ALUFlags !== 4'b0000) begin errors++; $display("FAIL midrst_flags got=%b exp=0000", bus_if.ALUFlags); end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((bus_if.done !== 1'b0) || (bus_if.busy !== 1'b0)) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL midrst_stray_activity got=%0d exp=0", stray); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        bus_if.start      = 1'b1;
        bus_if.ALUControl = 4'b0000;
        bus_if.a          = 32'd2;
        bus_if.b          = 32'd3;
        bus_if.carry_in   = 1'b0;
        @(negedge clk);
        checks++; if ((bus_if.done !== 1'b1) || (bus_if.Result !== 32'd5)) begin errors++; $display("FAIL b2b_add got=%b/%h exp=1/00000005", bus_if.done, bus_if.Result); end
        bus_if.ALUControl = 4'b0100;
        bus_if.a          = 32'hF0F0_F0F0;
        bus_if.b          = 32'hFF00_FF00;
        @(negedge clk);
        checks++; if ((bus_if.done !== 1'b1) || (bus_if.Result !== 32'h0FF0_0FF0)) begin errors++; $display("FAIL b2b_eor got=%b/%h exp=1/0ff00ff0", bus_if.done, bus_if.Result); end
        checks++; if (bus_if.ALUFlags !== 4'b0000) begin errors++; $display("FAIL b2b_eor_flags got=%b exp=0000", bus_if.ALUFlags); end
        bus_if.ALUControl = 4'b0101;
        bus_if.a          = 32'h0;
        bus_if.b          = 32'h8000_0000;
        @(negedge clk);
        bus_if.start = 1'b0;
        checks++; if ((bus_if.done !== 1'b1) || (bus_if.Result !== 32'h8000_0000)) begin errors++; $display("FAIL b2b_mov got=%b/%h exp=1/80000000", bus_if.done, bus_if.Result); end
        checks++; if (bus_if.ALUFlags !== 4'b1000) begin errors++; $display("FAIL b2b_mov_flags got=%b exp=1000", bus_if.ALUFlags); end
        @(negedge clk);
        checks++; if (bus_if.done !== 1'b0) begin errors++; $display("FAIL b2b_end_done got=%b exp=0", bus_if.done); end
        checks++; if (bus_if.Result !== 32'h8000_0000) begin errors++; $display("FAIL b2b_hold got=%h exp=80000000", bus_if.Result); end
    endtask

    task automatic test_reserved;
        do_op(4'b1110, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        checks++; if (bus_if.done !== 1'b1) begin errors++; $display("FAIL rsv14_done got=%b exp=1", bus_if.done); end
        checks++; if (bus_if.Result !== 32'h0) begin errors++; $display("FAIL rsv14_result got=%h exp=00000000", bus_if.Result); end
        checks++; if (bus_if.ALUFlags !== 4'b0100) begin errors++; $display("FAIL rsv14_flags got=%b exp=0100", bus_if.ALUFlags); end
        do_op(4'b0011, 32'h8000_0000, 32'h1, 1'b0);
        checks++; if (bus_if.Result !== 32'h8000_0001) begin errors++; $display("FAIL orr_result got=%h exp=80000001", bus_if.Result); end
        do_op(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        checks++; if ((bus_if.Result !== 32'h0) || (bus_if.ALUFlags !== 4'b0100)) begin errors++; $display("FAIL rsv15 got=%h/%b exp=00000000/0100", bus_if.Result, bus_if.ALUFlags); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_arith();
        test_shift();
        test_mul();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_reserved();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
